// File: rtl/intr_pkg.sv
// Shared types and constants for the intr_ctrl interrupt controller.
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intr_state_t;

  localparam int DEFAULT_ACK_TIMEOUT = 15;
  localparam int TMR_W               = 8;

endpackage

// File: rtl/intr_prio_arb.sv
// Combinational priority arbiter: the first eligible source found when
// searching upward (with wrap) from start wins; start = 0 gives fixed priority.
module intr_prio_arb #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [ID_W-1:0]    start,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id
);

  always_comb begin
    int idx;
    logic [ID_W-1:0] idx_w;
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    idx_w       = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      idx_w = ID_W'(idx);
      if (!grant_valid && eligible[idx_w]) begin
        grant_valid = 1'b1;
        grant_id    = idx_w;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Multi-source interrupt controller with req/ack/eoi handshake and ack timeout.
// Define INTR_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index.
//
// state   | meaning
// IDLE    | no request outstanding; arbitrate eligible sources
// REQ     | int_req high, waiting for int_ack or timeout
// SERVICE | core is servicing int_id; waiting for eoi
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int                 NUM_SRC     = 8,
  parameter int                 ID_W        = 3,
  parameter logic [NUM_SRC-1:0] EDGE_SEL    = {NUM_SRC{1'b1}},
  parameter int                 ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               int_ack,
  input  logic               eoi,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               timeout_flag
);

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT - 1);

  intr_state_t        state_q, state_d;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, sync2_d1_q;
  logic [NUM_SRC-1:0] edge_pend_q, edge_set, edge_clr;
  logic [NUM_SRC-1:0] mask_q, eligible;
  logic [ID_W-1:0]    id_q, id_d, start_ptr, grant_id;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               tflag_q, tflag_d, grant_valid, ack_take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync2_d1_q <= '0;
    end else begin
      sync1_q    <= irq_in;
      sync2_q    <= sync1_q;
      sync2_d1_q <= sync2_q;
    end
  end

  // A fresh edge on the cycle its bit is being acked must survive the clear.
  assign edge_set = sync2_q & ~sync2_d1_q & EDGE_SEL;
  assign edge_clr = ack_take ? ((NUM_SRC'(1) << id_q) & EDGE_SEL) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_pend_q <= '0;
      mask_q      <= '1;
    end else begin
      edge_pend_q <= (edge_pend_q & ~edge_clr) | edge_set;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  assign pending  = (edge_pend_q & EDGE_SEL) | (sync2_q & ~EDGE_SEL);
  assign eligible = pending & ~mask_q;

`ifdef INTR_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_ack_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          last_ack_q <= ID_W'(NUM_SRC - 1);
    else if (ack_take) last_ack_q <= id_q;
  end

  assign start_ptr = (last_ack_q == ID_W'(NUM_SRC - 1)) ? '0 : last_ack_q + ID_W'(1);
`else
  assign start_ptr = '0;
`endif

  intr_prio_arb #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_arb (
    .eligible    (eligible),
    .start       (start_ptr),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      timer_q <= '0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      timer_q <= timer_d;
      tflag_q <= tflag_d;
    end
  end

  // Timer counts down from ACK_TIMEOUT-1; reaching zero unacked withdraws.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    timer_d  = timer_q;
    tflag_d  = tflag_q;
    ack_take = 1'b0;
    if (mask_we) tflag_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = REQ;
          id_d    = grant_id;
          timer_d = TMR_LOAD;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d  = SERVICE;
          ack_take = 1'b1;
        end else if (timer_q == '0) begin
          state_d = IDLE;
          tflag_d = 1'b1;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      SERVICE: begin
        if (eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign int_req      = (state_q == REQ);
  assign int_id       = id_q;
  assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl (source 0 level, others edge).
`timescale 1ns/1ps
module tb_intr_ctrl;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_SRC-1:0] irq_in;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic               int_ack;
  logic               eoi;
  logic               int_req;
  logic [ID_W-1:0]    int_id;
  logic [NUM_SRC-1:0] pending;
  logic               timeout_flag;

  int n_chk  = 0;
  int n_fail = 0;

  intr_ctrl #(
    .NUM_SRC     (NUM_SRC),
    .ID_W        (ID_W),
    .EDGE_SEL    (8'hFE),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_in       (irq_in),
    .mask_we      (mask_we),
    .mask_wdata   (mask_wdata),
    .int_ack      (int_ack),
    .eoi          (eoi),
    .int_req      (int_req),
    .int_id       (int_id),
    .pending      (pending),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [NUM_SRC-1:0] m);
    mask_wdata = m;
    mask_we    = 1'b1;
    tick(1);
    mask_we    = 1'b0;
  endtask

  // Pulse one edge source; returns on the cycle its pending bit becomes visible.
  task automatic pulse_irq(input int b);
    irq_in[b] = 1'b1;
    tick(2);
    irq_in[b] = 1'b0;
    tick(1);
  endtask

  task automatic ack_eoi();
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    eoi     = 1'b1;
    tick(1);
    eoi     = 1'b0;
  endtask

  logic [ID_W-1:0] exp_r2, exp_r3;
  int cnt;

  initial begin
    rst = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; int_ack = 1'b0; eoi = 1'b0;
`ifdef INTR_ROUND_ROBIN_EN
    exp_r2 = 3'd5; exp_r3 = 3'd1;
`else
    exp_r2 = 3'd1; exp_r3 = 3'd5;
`endif
    #1;
    chk("rst_req", int_req, 0);
    chk("rst_id", int_id, 0);
    chk("rst_pend", pending, 0);
    chk("rst_tflag", timeout_flag, 0);
    tick(2);
    rst = 1'b1;

    // single edge source
    write_mask(8'h00);
    pulse_irq(3);
    chk("e3_pend", pending, 8'h08);
    chk("e3_req_early", int_req, 0);
    tick(1);
    chk("e3_req", int_req, 1);
    chk("e3_id", int_id, 3);
    int_ack = 1'b1; tick(1); int_ack = 1'b0;
    chk("e3_ack_pend", pending, 8'h00);
    chk("e3_ack_req", int_req, 0);
    chk("e3_svc_id", int_id, 3);
    eoi = 1'b1; tick(1); eoi = 1'b0;
    tick(1);
    chk("e3_idle_req", int_req, 0);

    // sources 1 and 5 together, then 1 again while in service
    irq_in = 8'h22; tick(2); irq_in = '0; tick(1);
    chk("p15_pend", pending, 8'h22);
    tick(1);
    chk("p15_id1", int_id, 1);
    chk("p15_req1", int_req, 1);
    int_ack = 1'b1; tick(1); int_ack = 1'b0;
    chk("p15_ack_pend", pending, 8'h20);
    pulse_irq(1);
    chk("p15_repend", pending, 8'h22);
    eoi = 1'b1; tick(1); eoi = 1'b0;
    chk("p15_eoi_req", int_req, 0);
    tick(1);
    chk("p15_id2", int_id, exp_r2);
    ack_eoi();
    tick(1);
    chk("p15_id3", int_id, exp_r3);
    chk("p15_req3", int_req, 1);
    ack_eoi();
    tick(1);
    chk("p15_done_pend", pending, 8'h00);
    chk("p15_done_req", int_req, 0);

    // masked source, stray ack/eoi ignored, then unmask
    write_mask(8'hFF);
    pulse_irq(2);
    chk("m2_pend", pending, 8'h04);
    int_ack = 1'b1; eoi = 1'b1; tick(1); int_ack = 1'b0; eoi = 1'b0;
    tick(2);
    chk("m2_masked_req", int_req, 0);
    chk("m2_pend_kept", pending, 8'h04);
    write_mask(8'hFB);
    chk("m2_req_early", int_req, 0);
    tick(1);
    chk("m2_req", int_req, 1);
    chk("m2_id", int_id, 2);
    ack_eoi();

    // ack timeout, re-request, ack on the timeout cycle
    write_mask(8'h00);
    pulse_irq(4);
    tick(1);
    chk("to_id", int_id, 4);
    cnt = 0;
    while (int_req === 1'b1 && cnt < 40) begin
      cnt++;
      tick(1);
    end
    chk("to_high_cycles", cnt, 15);
    chk("to_req_low", int_req, 0);
    chk("to_flag", timeout_flag, 1);
    chk("to_pend_kept", pending, 8'h10);
    tick(1);
    chk("to_rereq", int_req, 1);
    tick(14);
    chk("to_last_cycle", int_req, 1);
    int_ack = 1'b1; tick(1); int_ack = 1'b0;
    chk("to_ackwin_req", int_req, 0);
    chk("to_ackwin_pend", pending, 8'h00);
    chk("to_flag_sticky", timeout_flag, 1);
    eoi = 1'b1; tick(1); eoi = 1'b0;
    write_mask(8'h00);
    chk("to_flag_clr", timeout_flag, 0);

    // level source 0
    irq_in[0] = 1'b1;
    tick(2);
    chk("lv_pend", pending, 8'h01);
    tick(1);
    chk("lv_id", int_id, 0);
    chk("lv_req", int_req, 1);
    ack_eoi();
    chk("lv_eoi_pend", pending, 8'h01);
    tick(1);
    chk("lv_rereq", int_req, 1);
    irq_in[0] = 1'b0;
    write_mask(8'hFF);
    tick(2);
    chk("lv_drop_pend", pending, 8'h00);
    chk("lv_drop_req", int_req, 1);
    ack_eoi();
    tick(2);
    chk("lv_done_req", int_req, 0);

    // async reset during REQ
    write_mask(8'h00);
    pulse_irq(6);
    tick(1);
    chk("ar_req", int_req, 1);
    chk("ar_id", int_id, 6);
    #2 rst = 1'b0;
    #1;
    chk("ar_req_drop", int_req, 0);
    chk("ar_pend", pending, 8'h00);
    chk("ar_id_clr", int_id, 0);
    @(posedge clk); #1 rst = 1'b1;
    pulse_irq(6);
    tick(2);
    chk("ar_pend_masked", pending, 8'h40);
    chk("ar_no_req", int_req, 0);
    write_mask(8'h00);
    tick(1);
    chk("ar_req_after", int_req, 1);
    chk("ar_id_after", int_id, 6);
    ack_eoi();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
Parametrised multi-source interrupt controller that replaces the single INT line into the risc core. It synchronises NUM_SRC request lines, records per-source edge or level pending state and applies a software mask. It then raises one prioritised request to the core with a source ID, using a request/ack/end-of-interrupt handshake and an ack timeout.

Parameters:
NUM_SRC, 8, number of interrupt sources (2..32)
ID_W, 3, width of source ID; must equal clog2(NUM_SRC)
EDGE_SEL, 8'hFF, per-source mode: 1 = rising-edge, 0 = level
ACK_TIMEOUT, 15, cycles int_req waits for int_ack before withdrawal (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
irq_in  in  NUM_SRC  raw asynchronous interrupt lines
mask_we  in  1  mask register write strobe
mask_wdata  in  NUM_SRC  new mask value; 1 = source disabled
int_ack  in  1  core accepts request (single-cycle pulse)
eoi  in  1  core end-of-interrupt (single-cycle pulse)
int_req  out  1  interrupt request to core (drives core INT)
int_id  out  ID_W  ID of requested/in-service source
pending  out  NUM_SRC  pending bits, unmasked view
timeout_flag  out  1  sticky: a request timed out

Behaviour:
- Reset (rst=0, async): int_req=0, int_id=0, pending=0, timeout_flag=0, mask=all ones, sync flops=0, timer=0, state=IDLE.
- Input sync: 2-flop synchroniser per line.
  - Edge source: a rising edge of the synced signal sets pending[i]. Pending is visible 3 cycles after the irq_in rise.
  - Level source: pending[i] = synced level.
- Mask: mask_we loads mask_wdata at the clock edge. Eligible = pending & ~mask.
- FSM (2-bit state): IDLE, REQ, SERVICE.
  - IDLE: if eligible != 0, next cycle go to REQ. Latch int_id = winning source, set int_req=1, clear timer.
  - REQ: int_req held at 1, timer increments each cycle.
    - int_ack=1: go to SERVICE, int_req=0; clear pending[int_id] if that source is edge-type.
    - Timer reaches ACK_TIMEOUT with no ack: go to IDLE, int_req=0, set timeout_flag; pending is kept.
    - Ack on the same cycle as timeout: ack wins.
  - SERVICE: int_req=0, int_id held. eoi=1: go to IDLE. Re-arbitration possible the following cycle.
- Priority: fixed, lowest index wins.
- Edge cases:
  - New edge on the same cycle as its ack-clear: the set wins and the bit stays pending.
  - Edge while a bit is already pending is merged (not counted).
  - Mask change during REQ does not withdraw the latched request.
  - int_ack outside REQ and eoi outside SERVICE are ignored.
  - Level source deasserting during REQ: request continues.
  - timeout_flag clears only on reset or on a mask_we cycle.
  - Async reset mid-handshake returns everything to reset values immediately; int_req drops without a clock.

Optional Feature:
INTR_ROUND_ROBIN_EN
- Defined: rotating priority. Search starts at (last acknowledged ID + 1) mod NUM_SRC; the last-ack pointer resets to NUM_SRC-1, so the first arbitration favours ID 0.
- Undefined: fixed lowest-index priority; no pointer register exists.

Decomposition:
- Package intr_pkg: state encodings IDLE=2'd0, REQ=2'd1, SERVICE=2'd2; a default-timeout constant.
- One sub-module: intr_prio_arb, a combinational arbiter.
  - Inputs: eligible vector and start pointer.
  - Outputs: grant_valid and grant_id.
  - Handles both fixed and rotating modes.

Test Plan:
- Reset then pulse irq_in[3] (edge), mask=8'h00 -> int_req rises 4 cycles after the irq edge with int_id=3; ack -> pending[3]=0; eoi -> back to IDLE.
- irq_in[5] and irq_in[1] rise on the same cycle -> int_id=1 first; after eoi, int_id=5 (fixed priority). With INTR_ROUND_ROBIN_EN, repeated 1/5 requests alternate 1,5,1,5.
- Mask left at reset 8'hFF, irq_in[2] pulses -> pending[2]=1, int_req stays 0; write mask 8'hFB -> int_req asserts with int_id=2.
- Request with no ack, ACK_TIMEOUT=15 -> int_req high exactly 15 cycles, then low; timeout_flag=1; re-request follows; mask_we clears the flag.
- Level source (EDGE_SEL bit 0 = 0) held high through ack and eoi -> re-requested immediately after eoi; dropped before ack -> request still completes.
- Assert rst=0 while in REQ -> int_req=0 asynchronously, mask=all ones, pending=0; after release, no request until mask is written.
